uart_prog_loader: RTL and testbench

//  Program-load front end for crv32 debug memory port: consumes bytes from UART0 RX, holds CPU in reset,

---
 rtl/uart_prog_loader.sv | 132 +++++++++++++
 tb/tb_uart_prog_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART byte-stream program loader driving the crv32 debug memory port
module uart_prog_loader #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        cpu_n_reset,
    output logic        dbg_mem_op,
    output logic [3:0]  dbg_wren,
    output logic [31:0] dbg_adr,
    output logic [31:0] dbg_do
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, WRITE, CSUM, RESP} state_t;
    state_t state, state_next;
    logic [31:0] addr;
    logic [23:0] word;
    logic [15:0] remaining;
    logic [7:0]  csum, skid_data, cur_byte, resp_code;
    logic [1:0]  byte_cnt;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic skid_full, run, accepting, have_byte, tmo_active, timeout, overrun, write_done;
    assign dbg_wren   = (state == WRITE) ? 4'hF : 4'h0;
    assign dbg_mem_op = ~cpu_n_reset;
    // byte source selection (skid byte first), abort and write-completion conditions
    always_comb begin
        accepting  = state != WRITE && state != RESP;
        tmo_active = state == ADDR || state == COUNT || state == DATA || state == CSUM;
        have_byte  = accepting && (skid_full || rx_valid);
        cur_byte   = skid_full ? skid_data : rx_data;
        overrun    = !accepting && rx_valid && skid_full;
        timeout    = tmo_active && !have_byte && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
        write_done = state == WRITE && hold_cnt == HW'(HOLD_CYCLES - 1);
    end
    // frame parser next state and response code
    always_comb begin
        state_next = state;
        resp_code  = 8'h15;
        case (state)
            IDLE: begin
                if (have_byte && cur_byte == 8'hA5) state_next = ADDR;
                else if (have_byte && cur_byte == 8'h5A) begin
                    state_next = RESP;
                    resp_code  = 8'h06;
                end
            end
            ADDR:  if (have_byte && byte_cnt == 2'd3) state_next = COUNT;
            COUNT: if (have_byte && byte_cnt == 2'd1) state_next = ({cur_byte, remaining[15:8]} == 16'd0) ? CSUM : DATA;
            DATA:  if (have_byte && byte_cnt == 2'd3) state_next = WRITE;
            WRITE: begin
                if (overrun) state_next = RESP;
                else if (write_done) state_next = (remaining == 16'd1) ? CSUM : DATA;
            end
            CSUM: begin
                if (have_byte) begin
                    state_next = RESP;
                    resp_code  = (cur_byte == csum) ? 8'h06 : 8'h15;
                end
            end
            RESP:    if (tx_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (timeout) state_next = RESP;
    end
    // state register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else state <= state_next;
    end
    // datapath: skid, counters, frame fields, debug bus and UART response
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            addr        <= '0;
            word        <= '0;
            remaining   <= '0;
            csum        <= '0;
            skid_data   <= '0;
            skid_full   <= 1'b0;
            byte_cnt    <= '0;
            hold_cnt    <= '0;
            tmo_cnt     <= '0;
            run         <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            cpu_n_reset <= 1'b0;
            dbg_adr     <= '0;
            dbg_do      <= '0;
        end else begin
            skid_full <= accepting ? (skid_full && rx_valid) : (rx_valid ? !skid_full : skid_full);
            if (rx_valid) skid_data <= rx_data;
            tmo_cnt  <= (tmo_active && !rx_valid) ? tmo_cnt + TW'(1) : '0;
            hold_cnt <= (state == WRITE) ? hold_cnt + HW'(1) : '0;
            if (have_byte && state == IDLE && cur_byte == 8'hA5) begin
                byte_cnt    <= '0;
                csum        <= '0;
                cpu_n_reset <= 1'b0;
            end
            if (have_byte && (state == ADDR || state == COUNT || state == DATA)) begin
                csum     <= csum + cur_byte;
                byte_cnt <= (state == COUNT && byte_cnt == 2'd1) ? 2'd0 : byte_cnt + 2'd1;
            end
            if (have_byte && state == ADDR) addr <= {cur_byte, addr[31:8]};
            if (have_byte && state == COUNT) remaining <= {cur_byte, remaining[15:8]};
            if (have_byte && state == DATA) word <= {cur_byte, word[23:8]};
            if (have_byte && state == DATA && byte_cnt == 2'd3) begin
                dbg_adr <= addr;
                dbg_do  <= {cur_byte, word};
            end
            if (write_done && !overrun) begin
                addr      <= addr + 32'd4;
                remaining <= remaining - 16'd1;
            end
            if (state != RESP && state_next == RESP) begin
                tx_valid <= 1'b1;
                tx_data  <= resp_code;
                run      <= state == IDLE;
            end
            if (state == RESP && tx_ready) begin
                tx_valid <= 1'b0;
                if (run) cpu_n_reset <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed self-checking bench for the UART program loader
module tb_uart_prog_loader;
    localparam int HOLD = 16;
    localparam int TMO  = 300;
    logic        clk = 1'b0, n_reset = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid, cpu_n_reset, dbg_mem_op;
    logic [7:0]  tx_data;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr, dbg_do;
    int n_checks = 0, n_fail = 0;
    typedef struct {logic [31:0] adr; logic [31:0] dat; int len;} wr_t;
    wr_t wq[$];
    wr_t cur;
    bit in_wr = 0;
    int bus_err = 0;
    logic [7:0] frame[$];
    uart_prog_loader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .n_reset(n_reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .cpu_n_reset(cpu_n_reset), .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren),
        .dbg_adr(dbg_adr), .dbg_do(dbg_do)
    );
    always #5 clk = ~clk;
    // record each write burst (address, data, length) and flag unstable bus or bad enables
    always @(negedge clk) begin
        if (dbg_mem_op !== ~cpu_n_reset) bus_err++;
        if (dbg_wren === 4'hF) begin
            if (!in_wr) begin
                cur.adr = dbg_adr;
                cur.dat = dbg_do;
                cur.len = 0;
            end
            in_wr = 1;
            cur.len++;
            if (dbg_adr !== cur.adr || dbg_do !== cur.dat) bus_err++;
        end else begin
            if (dbg_wren !== 4'h0) bus_err++;
            if (in_wr) wq.push_back(cur);
            in_wr = 0;
        end
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask
    task automatic send_frame(input int nwords);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            if (i >= 7 && i < 7 + 4 * nwords && (i - 6) % 4 == 0) repeat (20) @(negedge clk);
        end
    endtask
    task automatic get_resp(input logic [7:0] exp, input string tag, output int waited);
        waited = 0;
        while (tx_valid !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " valid"}, {31'd0, tx_valid}, 32'd1);
        check({tag, " data"}, {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check({tag, " drop"}, {31'd0, tx_valid}, 32'd0);
    endtask
    initial begin
        int w, bad;
        logic [31:0] exp_adr[3];
        logic [31:0] exp_dat[3];
        exp_adr = '{32'h0002_0000, 32'h0002_0004, 32'h0002_0008};
        exp_dat = '{32'h0001_07b7, 32'h0007_a023, 32'h0000_006f};
        repeat (3) @(negedge clk);
        check("rst cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
        check("rst mem_op", {31'd0, dbg_mem_op}, 32'd1);
        check("rst wren", {28'd0, dbg_wren}, 32'd0);
        check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'd0);
        check("rst adr", dbg_adr, 32'd0);
        check("rst do", dbg_do, 32'd0);
        n_reset = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (cpu_n_reset !== 1'b0 || dbg_mem_op !== 1'b1 || dbg_wren !== 4'h0 || tx_valid !== 1'b0) bad++;
        end
        check("t1 idle hold", bad, 0);
        frame = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
                  8'hb7, 8'h07, 8'h01, 8'h00, 8'h23, 8'ha0, 8'h07, 8'h00,
                  8'h6f, 8'h00, 8'h00, 8'h00, 8'hFD};
        for (int t = 0; t < 2; t++) begin
            wq.delete();
            frame[19] = (t == 0) ? 8'hFD : 8'hFE;
            send_frame(3);
            get_resp((t == 0) ? 8'h06 : 8'h15, (t == 0) ? "t2 resp" : "t3 resp", w);
            check("t2/3 nwrites", wq.size(), 3);
            for (int i = 0; i < 3; i++) begin
                if (i < wq.size()) begin
                    check("t2/3 adr", wq[i].adr, exp_adr[i]);
                    check("t2/3 dat", wq[i].dat, exp_dat[i]);
                    check("t2/3 len", wq[i].len, HOLD);
                end
            end
            check("t2/3 cpu held", {31'd0, cpu_n_reset}, 32'd0);
        end
        send_byte(8'h5A);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h06 || cpu_n_reset !== 1'b0) bad++;
        end
        check("t4 resp held", bad, 0);
        get_resp(8'h06, "t4 resp", w);
        check("t4 cpu run", {31'd0, cpu_n_reset}, 32'd1);
        check("t4 mem_op", {31'd0, dbg_mem_op}, 32'd0);
        wq.delete();
        send_byte(8'hA5);
        check("t5 cpu reheld", {31'd0, cpu_n_reset}, 32'd0);
        frame = '{8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (frame[i]) send_byte(frame[i]);
        repeat (20) @(negedge clk);
        frame = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00};
        foreach (frame[i]) send_byte(frame[i]);
        get_resp(8'h15, "t5 overrun", w);
        check("t5 nwrites", wq.size(), 2);
        if (wq.size() == 2) begin
            check("t5 adr0", wq[0].adr, 32'hFFFF_FFFC);
            check("t5 dat0", wq[0].dat, 32'h4433_2211);
            check("t5 len0", wq[0].len, HOLD);
            check("t5 adr1 wrap", wq[1].adr, 32'h0000_0000);
            check("t5 dat1", wq[1].dat, 32'h8877_6655);
            check("t5 len1 aborted", {31'd0, wq[1].len > 0 && wq[1].len < HOLD}, 32'd1);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        get_resp(8'h15, "t6 timeout", w);
        check("t6 latency", {31'd0, w >= TMO - 2 && w <= TMO + 2}, 32'd1);
        send_byte(8'h5A);
        get_resp(8'h06, "t6 run", w);
        check("t6 cpu run", {31'd0, cpu_n_reset}, 32'd1);
        send_byte(8'h5A);
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        check("mid rst tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid rst tx_data", {24'd0, tx_data}, 32'd0);
        check("mid rst cpu", {31'd0, cpu_n_reset}, 32'd0);
        check("mid rst mem_op", {31'd0, dbg_mem_op}, 32'd1);
        check("mid rst do", dbg_do, 32'd0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        send_byte(8'h5A);
        get_resp(8'h06, "post rst run", w);
        check("bus integrity", bus_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
